// File: rtl/apple1_ram_loader_pkg.sv
// Shared types and constants for the Apple-1 RAM loader.
package apple1_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_LO,
    ST_HDR_HI,
    ST_DATA,
    ST_DRAIN
  } loader_state_e;

  localparam int unsigned HDR_BYTES       = 2;
  localparam int unsigned HDR_BITS        = 8 * HDR_BYTES;
  localparam logic [15:0] RAM_TOP_DEFAULT = 16'hBFFF;

  typedef logic [HDR_BITS-1:0] load_addr_t;

  // A pop only reaches RAM when the pointer is still inside the writable window.
  function automatic logic addr_writable(input logic [15:0] ptr,
                                         input logic        past_end,
                                         input logic [15:0] top);
    return !past_end && (ptr <= top);
  endfunction

endpackage

// File: rtl/apple1_ram_loader_if.sv
// RAM write-port bundle shared between the loader (master) and the RAM (slave).
interface apple1_ram_loader_if;
  logic        ram_slot;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;

  modport master (
    input  ram_slot,
    output ram_addr,
    output ram_din,
    output ram_we
  );

  modport slave (
    output ram_slot,
    input  ram_addr,
    input  ram_din,
    input  ram_we
  );
endinterface

// File: rtl/apple1_ram_loader_fifo.sv
// Small synchronous byte FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module loader_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_clr,
  input  logic       i_push,
  input  logic [7:0] i_din,
  input  logic       i_pop,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_drop,
  output logic [7:0] o_dout
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  always_comb begin
    o_full    = (r_count == FULL_CNT);
    o_empty   = (r_count == '0);
    w_do_pop  = i_pop && !o_empty && !i_clr;
    w_do_push = i_push && !i_clr && (!o_full || w_do_pop);
    o_drop    = i_push && !i_clr && !w_do_push;
    o_dout    = r_mem[r_rd_ptr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)
        r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push)
        r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/apple1_ram_loader.sv
// Writes a downloaded file (2-byte LE load address + data) into system RAM using free RAM slots.
// Optional LOADER_CHECKSUM_EN adds a modulo-256 sum of the bytes actually written.
module apple1_ram_loader
  import apple1_loader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] RAM_TOP    = RAM_TOP_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       dl_active,
  input  logic                       dl_wr,
  input  logic [7:0]                 dl_data,
  apple1_ram_loader_if.master        ram,
  output logic                       cpu_hold,
  output load_addr_t                 load_addr,
  output logic                       overflow
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]                 checksum
`endif
);

  loader_state_e r_state;
  loader_state_e w_next;

  logic        w_enter_hdr;
  logic        w_hdr_lo_wr;
  logic        w_hdr_hi_wr;
  logic        w_push;
  logic        w_pop;
  logic        w_write;
  logic        w_discard;
  logic        w_writable;
  logic        w_full;
  logic        w_empty;
  logic        w_drop;
  logic [7:0]  w_fifo_dout;

  logic        r_cpu_hold;
  logic        r_overflow;
  logic        r_ram_we;
  logic [15:0] r_ram_addr;
  logic [7:0]  r_ram_din;
  load_addr_t  r_load_addr;
  logic [15:0] r_ptr;
  logic        r_ptr_past;

  assign w_writable = addr_writable(r_ptr, r_ptr_past, RAM_TOP);

  always_comb begin
    w_next      = r_state;
    w_enter_hdr = 1'b0;
    w_hdr_lo_wr = 1'b0;
    w_hdr_hi_wr = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (dl_active) begin
          w_next      = ST_HDR_LO;
          w_enter_hdr = 1'b1;
        end
      end
      ST_HDR_LO: begin
        if (!dl_active) begin
          w_next = ST_IDLE;
        end else if (dl_wr) begin
          w_next      = ST_HDR_HI;
          w_hdr_lo_wr = 1'b1;
        end
      end
      ST_HDR_HI: begin
        if (!dl_active) begin
          w_next = ST_IDLE;
        end else if (dl_wr) begin
          w_next      = ST_DATA;
          w_hdr_hi_wr = 1'b1;
        end
      end
      ST_DATA: begin
        w_push = dl_wr;
        w_pop  = ram.ram_slot && !w_empty;
        if (!dl_active) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_pop = ram.ram_slot && !w_empty;
        // An empty FIFO means the last write (if any) is already on the RAM port.
        if (w_empty) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    w_write   = w_pop && w_writable;
    w_discard = w_pop && !w_writable;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cpu_hold <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cpu_hold <= (w_next != ST_IDLE);
    end
  end

  // The pointer saturates at 16'hFFFF; r_ptr_past marks that it has run off the end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_load_addr <= '0;
      r_ptr       <= '0;
      r_ptr_past  <= 1'b0;
    end else begin
      if (w_hdr_lo_wr) r_load_addr[7:0] <= dl_data;
      if (w_hdr_hi_wr) begin
        r_load_addr[15:8] <= dl_data;
        r_ptr             <= {dl_data, r_load_addr[7:0]};
        r_ptr_past        <= 1'b0;
      end else if (w_pop) begin
        if (r_ptr == '1) r_ptr_past <= 1'b1;
        else             r_ptr      <= r_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
    end else begin
      r_ram_we <= w_write;
      if (w_write) begin
        r_ram_addr <= r_ptr;
        r_ram_din  <= w_fifo_dout;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_overflow <= 1'b0;
    else if (w_enter_hdr)
      r_overflow <= 1'b0;
    else if (w_drop || w_discard)
      r_overflow <= 1'b1;
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_checksum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_checksum <= '0;
    else if (w_enter_hdr)
      r_checksum <= '0;
    else if (w_write)
      r_checksum <= r_checksum + w_fifo_dout;
  end

  assign checksum = r_checksum;
`endif

  loader_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_enter_hdr),
    .i_push  (w_push),
    .i_din   (dl_data),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_drop  (w_drop),
    .o_dout  (w_fifo_dout)
  );

  assign ram.ram_we   = r_ram_we;
  assign ram.ram_addr = r_ram_addr;
  assign ram.ram_din  = r_ram_din;
  assign cpu_hold     = r_cpu_hold;
  assign load_addr    = r_load_addr;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_apple1_ram_loader.sv
// Self-checking bench for apple1_ram_loader: fixed download table, hand-written corner sequences, random downloads.
module tb_apple1_ram_loader;
  import apple1_loader_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] TOP   = 16'hBFFF;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b0;
  logic        dl_active = 1'b0;
  logic        dl_wr     = 1'b0;
  logic [7:0]  dl_data   = 8'h00;
  logic        cpu_hold;
  logic [15:0] load_addr;
  logic        overflow;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  apple1_ram_loader_if ram_bus();

  apple1_ram_loader #(
    .FIFO_DEPTH (DEPTH),
    .RAM_TOP    (TOP)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .dl_active (dl_active),
    .dl_wr     (dl_wr),
    .dl_data   (dl_data),
    .ram       (ram_bus),
    .cpu_hold  (cpu_hold),
    .load_addr (load_addr),
    .overflow  (overflow)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitor: every RAM write seen, tagged with the edge number that launched it.
  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t  dut_log[$];
  wr_t  exp_log[$];
  int   cyc          = 0;
  logic slot_at_edge = 1'b0;
  int   bad_slot_we  = 0;

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    slot_at_edge <= ram_bus.ram_slot;
  end

  always @(negedge clk) begin
    if (ram_bus.ram_we === 1'b1) begin
      dut_log.push_back('{cyc, ram_bus.ram_addr, ram_bus.ram_din});
      if (!slot_at_edge) bad_slot_we++;
    end
  end

  logic [7:0] stream[$];

  function automatic logic slot_val(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 4) == 3;
      default: return $urandom_range(0, 1) == 1;
    endcase
  endfunction

  // Plays `stream` (header + data) as one download and predicts the RAM writes:
  // bytes queue in a DEPTH-entry buffer, one leaves per free slot, and addresses
  // above TOP swallow the byte instead of writing it.
  task automatic run_download(input int slot_mode, input int wr_mode,
                              output logic [15:0] m_addr, output logic m_ovf,
                              output logic [7:0] m_sum);
    logic [7:0] q[$];
    int   k = 0, idx = 0, hdr = 0, budget = 0;
    int   m_ptr = 0;
    logic wr, slot;
    logic [7:0] b;

    m_addr = load_addr;
    m_ovf  = 1'b0;
    m_sum  = 8'h00;
    exp_log.delete();
    dut_log.delete();
    bad_slot_we = 0;

    dl_active = 1'b1; dl_wr = 1'b0; ram_bus.ram_slot = slot_val(slot_mode, k); k++;
    @(posedge clk); #1;
    check("hold_rise", {63'd0, cpu_hold}, 64'd1);
    check("ovf_clear", {63'd0, overflow}, 64'd0);
`ifdef LOADER_CHECKSUM_EN
    check("cks_clear", {56'd0, checksum}, 64'd0);
`endif

    while (idx < stream.size() && budget < 500) begin
      wr   = (wr_mode == 0) || ($urandom_range(0, 1) == 1);
      slot = slot_val(slot_mode, k); k++;
      b    = wr ? stream[idx] : 8'h00;
      dl_wr = wr; dl_data = b; ram_bus.ram_slot = slot;
      @(posedge clk); #1;
      budget++;
      if (hdr < 2) begin
        if (wr) begin
          if (hdr == 0) m_addr[7:0] = b; else m_addr[15:8] = b;
          hdr++;
          if (hdr == 2) m_ptr = int'(m_addr);
        end
      end else begin
        if (slot && q.size() > 0) begin
          logic [7:0] pb = q.pop_front();
          if (m_ptr <= int'(TOP)) begin
            exp_log.push_back('{cyc, m_ptr[15:0], pb});
            m_sum += pb;
          end else m_ovf = 1'b1;
          m_ptr++;
        end
        if (wr) begin
          if (q.size() < DEPTH) q.push_back(b); else m_ovf = 1'b1;
        end
      end
      if (wr) idx++;
    end
    if (budget >= 500) check("stream_budget", 64'(budget), 64'd0);

    dl_active = 1'b0; dl_wr = 1'b0; dl_data = 8'h00;
    budget = 0;
    do begin
      slot = slot_val(slot_mode, k); k++;
      ram_bus.ram_slot = slot;
      @(posedge clk); #1;
      budget++;
      if (slot && q.size() > 0) begin
        logic [7:0] pb = q.pop_front();
        if (m_ptr <= int'(TOP)) begin
          exp_log.push_back('{cyc, m_ptr[15:0], pb});
          m_sum += pb;
        end else m_ovf = 1'b1;
        m_ptr++;
      end
    end while (q.size() > 0 && budget < 200);
    if (budget >= 200) check("drain_budget", 64'(budget), 64'd0);
    check("hold_last_write", {63'd0, cpu_hold}, 64'd1);
    ram_bus.ram_slot = slot_val(slot_mode, k);
    @(posedge clk); #1;
    check("hold_fall", {63'd0, cpu_hold}, 64'd0);
    ram_bus.ram_slot = 1'b0;
    @(posedge clk); #1;

    check("wr_count", 64'(dut_log.size()), 64'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < dut_log.size(); i++)
      check("wr_entry", {16'(dut_log[i].cyc), dut_log[i].addr, dut_log[i].data},
                        {16'(exp_log[i].cyc), exp_log[i].addr, exp_log[i].data});
    check("we_only_in_slot", 64'(bad_slot_we), 64'd0);
    check("load_addr", {48'd0, load_addr}, {48'd0, m_addr});
    check("overflow", {63'd0, overflow}, {63'd0, m_ovf});
`ifdef LOADER_CHECKSUM_EN
    check("checksum", {56'd0, checksum}, {56'd0, m_sum});
`endif
  endtask

  typedef struct {
    logic [7:0]  b[10];
    int          n;
    int          slot_mode;
    logic [15:0] exp_addr;
    logic        exp_ovf;
    logic [7:0]  exp_cks;
  } vec_t;

  vec_t        vecs[5];
  logic [15:0] m_addr;
  logic        m_ovf;
  logic [7:0]  m_sum;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{'{8'hFE, 8'hBF, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5, 0, 16'hBFFE, 1'b1, 8'h03};
    vecs[1] = '{'{8'h02, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5, 0, 16'h0302, 1'b0, 8'h31};
    vecs[2] = '{'{8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88}, 10, 1, 16'h0302, 1'b1, 8'hFF};
    vecs[3] = '{'{8'hFF, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 0, 16'hFFFF, 1'b1, 8'h00};
    vecs[4] = '{'{8'h00, 8'h10, 8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00}, 6, 2, 16'h1000, 1'b0, 8'hA0};

    ram_bus.ram_slot = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold", {63'd0, cpu_hold}, 64'd0);
    check("rst_we", {63'd0, ram_bus.ram_we}, 64'd0);
    check("rst_addr", {48'd0, ram_bus.ram_addr}, 64'd0);
    check("rst_load_addr", {48'd0, load_addr}, 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      stream.delete();
      for (int j = 0; j < vecs[i].n; j++) stream.push_back(vecs[i].b[j]);
      run_download(vecs[i].slot_mode, 0, m_addr, m_ovf, m_sum);
      check("vec_load_addr", {48'd0, load_addr}, {48'd0, vecs[i].exp_addr});
      check("vec_overflow", {63'd0, overflow}, {63'd0, vecs[i].exp_ovf});
`ifdef LOADER_CHECKSUM_EN
      check("vec_checksum", {56'd0, checksum}, {56'd0, vecs[i].exp_cks});
`endif
    end

    // Download abandoned after one header byte.
    dut_log.delete();
    dl_active = 1'b1; dl_wr = 1'b0;
    @(posedge clk); #1;
    dl_wr = 1'b1; dl_data = 8'h34;
    @(posedge clk); #1;
    dl_wr = 1'b0; dl_active = 1'b0; ram_bus.ram_slot = 1'b1;
    @(posedge clk); #1;
    check("abort_hold", {63'd0, cpu_hold}, 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_we", 64'(dut_log.size()), 64'd0);
    check("abort_ovf", {63'd0, overflow}, 64'd0);
    check("abort_addr_lo", {56'd0, load_addr[7:0]}, 64'h34);
    ram_bus.ram_slot = 1'b0;

    // Reset while two data bytes sit in the buffer.
    dl_active = 1'b1;
    @(posedge clk); #1;
    dl_wr = 1'b1; dl_data = 8'h00;
    @(posedge clk); #1;
    dl_data = 8'h20;
    @(posedge clk); #1;
    dl_data = 8'hE1;
    @(posedge clk); #1;
    dl_data = 8'hE2;
    @(posedge clk); #1;
    dl_wr = 1'b0;
    check("pre_rst_hold", {63'd0, cpu_hold}, 64'd1);
    dut_log.delete();
    #2 reset_n = 1'b0;
    #1;
    check("midrst_hold", {63'd0, cpu_hold}, 64'd0);
    check("midrst_we", {63'd0, ram_bus.ram_we}, 64'd0);
    check("midrst_addr", {48'd0, ram_bus.ram_addr}, 64'd0);
    check("midrst_din", {56'd0, ram_bus.ram_din}, 64'd0);
    check("midrst_load_addr", {48'd0, load_addr}, 64'd0);
    check("midrst_ovf", {63'd0, overflow}, 64'd0);
`ifdef LOADER_CHECKSUM_EN
    check("midrst_cks", {56'd0, checksum}, 64'd0);
`endif
    dl_active = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    ram_bus.ram_slot = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("postrst_no_we", 64'(dut_log.size()), 64'd0);
    check("postrst_hold", {63'd0, cpu_hold}, 64'd0);
    ram_bus.ram_slot = 1'b0;

    // Random back-to-back downloads against the queue model.
    for (int t = 0; t < 12; t++) begin
      logic [15:0] a;
      int len;
      case ($urandom_range(0, 2))
        0:       a = 16'($urandom);
        1:       a = TOP - 16'($urandom_range(0, 8));
        default: a = 16'hFFF8 + 16'($urandom_range(0, 7));
      endcase
      len = $urandom_range(0, 12);
      stream.delete();
      stream.push_back(a[7:0]);
      stream.push_back(a[15:8]);
      for (int j = 0; j < len; j++) stream.push_back(8'($urandom));
      run_download(2, 1, m_addr, m_ovf, m_sum);
      check("rand_load_addr", {48'd0, load_addr}, {48'd0, a});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
